uart_receive: RTL

Serial receive engine for the UART: the counterpart of the transmit block, sharing its frame format, configuration inputs (PEN, OHEL, EIGHT) and bit-time count (BAUD_COUNT). It synchronises the asynchronous RX line, detects and qualifies the start bit, samples each bit at mid-bit, checks parity and stop, and presents the received byte with ready and error flags for the processor's input port.

---
 rtl/uart_receive_if.sv | 36 +++
 rtl/uart_receive.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_receive_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receive_if
// Description : Processor-side port of the UART receiver. It carries the
//               received character, the status flags and the read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receive_if;
  logic       CLR;        // one-cycle read strobe from the processor
  logic [7:0] UART_DATA;  // received character (bit 7 = 0 in 7-bit mode)
  logic       RX_RDY;     // new character available
  logic       PERR;       // parity error on the last character
  logic       FERR;       // framing error on the last character
  logic       OVF;        // overrun, sticky until CLR

  // Receiver side: drives data and flags, consumes the read strobe.
  modport master (
    input  CLR,
    output UART_DATA,
    output RX_RDY,
    output PERR,
    output FERR,
    output OVF
  );

  // Processor side: reads data and flags, issues the read strobe.
  modport slave (
    output CLR,
    input  UART_DATA,
    input  RX_RDY,
    input  PERR,
    input  FERR,
    input  OVF
  );
endinterface
`default_nettype wire

// File: rtl/uart_receive.sv
`default_nettype none
// ============================================================================
// Module      : uart_receive
// Description : UART serial receive engine. The RX line is synchronised and
//               the start bit is qualified at mid-bit. Each following bit is
//               then sampled one bit time later. Parity and stop are checked
//               and the character is presented with ready/error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receive (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        RX,
  input  wire logic        PEN,
  input  wire logic        OHEL,
  input  wire logic        EIGHT,
  input  wire logic [18:0] BAUD_COUNT,
  uart_receive_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    LOAD  = 2'd3
  } state_t;

  // Line synchroniser: both flops idle high so reset never looks like a start.
  logic        rx_meta;
  logic        rxs;

  // Receive state.
  state_t      state;
  logic [18:0] bit_timer;     // clocks elapsed within the current bit
  logic [3:0]  bit_cnt;       // samples taken since the start bit
  logic [9:0]  shift_reg;     // newest sample enters at bit 9
  logic        pen_lat;       // frame format frozen for the frame in progress
  logic        ohel_lat;
  logic        eight_lat;

  // Derived values.
  logic [18:0] half_count;
  logic [3:0]  num_samples;
  logic [7:0]  rx_data;
  logic        parity_bit;
  logic        parity_exp;
  logic        parity_err;
  logic        stop_bit;

  // Mid-bit point of the start bit, measured from entry into START.
  assign half_count  = BAUD_COUNT >> 1;

  // Samples after the start bit: data bits, optional parity, stop.
  assign num_samples = 4'd8 + {3'b000, eight_lat} + {3'b000, pen_lat};

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  // Character extraction from the shift register after the last sample.
  // The stop bit is always at bit 9 and parity (when present) at bit 8;
  // data sits right-aligned below them depending on the frame format.
  always_comb begin
    rx_data    = 8'h00;
    parity_bit = shift_reg[8];
    stop_bit   = shift_reg[9];
    case ({eight_lat, pen_lat})
      2'b11:   rx_data = shift_reg[7:0];
      2'b10:   rx_data = shift_reg[8:1];
      2'b01:   rx_data = {1'b0, shift_reg[7:1]};
      default: rx_data = {1'b0, shift_reg[8:2]};
    endcase
    // Bit 7 is zero in 7-bit mode, so an 8-bit XOR covers both widths.
    parity_exp = (^rx_data) ^ ohel_lat;
    parity_err = pen_lat & (parity_bit != parity_exp);
  end

  // Receive state machine with registered processor-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_timer     <= 19'd0;
      bit_cnt       <= 4'd0;
      shift_reg     <= 10'h3FF;
      pen_lat       <= 1'b0;
      ohel_lat      <= 1'b0;
      eight_lat     <= 1'b0;
      bus.UART_DATA <= 8'h00;
      bus.RX_RDY    <= 1'b0;
      bus.PERR      <= 1'b0;
      bus.FERR      <= 1'b0;
      bus.OVF       <= 1'b0;
    end else begin
      // A read strobe clears the flags; a load in the same cycle overrides it.
      if (bus.CLR) begin
        bus.RX_RDY <= 1'b0;
        bus.OVF    <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_timer <= 19'd0;
          bit_cnt   <= 4'd0;
          if (!rxs) begin
            state <= START;
          end
        end

        START: begin
          if (bit_timer == half_count) begin
            bit_timer <= 19'd0;
            bit_cnt   <= 4'd0;
            if (rxs) begin
              // Line went back high before mid-bit: glitch, not a start.
              state <= IDLE;
            end else begin
              state     <= DATA;
              pen_lat   <= PEN;
              ohel_lat  <= OHEL;
              eight_lat <= EIGHT;
            end
          end else begin
            bit_timer <= bit_timer + 19'd1;
          end
        end

        DATA: begin
          if (bit_timer == BAUD_COUNT) begin
            bit_timer <= 19'd0;
            shift_reg <= {rxs, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            if ((bit_cnt + 4'd1) == num_samples) begin
              state <= LOAD;
            end
          end else begin
            bit_timer <= bit_timer + 19'd1;
          end
        end

        LOAD: begin
          bus.UART_DATA <= rx_data;
          bus.PERR      <= parity_err;
          bus.FERR      <= ~stop_bit;
          bus.RX_RDY    <= 1'b1;
          // Overrun only if the previous character was never read.
          if (bus.RX_RDY && !bus.CLR) begin
            bus.OVF <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
